// File: rtl/delta_demodulator_multichannel_if.sv
// Beat/config/output bundle for delta_demodulator_multichannel.
//   master : beat source + config writer (drives en/spikes/sync/clr/cfg_*,
//            receives sample_out/channel_out/valid_out/err)
//   slave  : the demodulator
interface delta_demodulator_multichannel_if #(
  parameter int CHANNELS = 16,
  parameter int WIDTH    = 16
) ();
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                    en;
  logic                    pos_spike;
  logic                    neg_spike;
  logic                    sync;
  logic                    clr;
  logic                    cfg_we;
  logic [CW-1:0]           cfg_addr;
  logic signed [WIDTH-1:0] cfg_delta;
  logic signed [WIDTH-1:0] sample_out;
  logic [CW-1:0]           channel_out;
  logic                    valid_out;
  logic                    err;

  modport master (
    output en, pos_spike, neg_spike, sync, clr, cfg_we, cfg_addr, cfg_delta,
    input  sample_out, channel_out, valid_out, err
  );

  modport slave (
    input  en, pos_spike, neg_spike, sync, clr, cfg_we, cfg_addr, cfg_delta,
    output sample_out, channel_out, valid_out, err
  );
endinterface

// File: rtl/delta_demodulator_multichannel.sv
// Multichannel delta demodulator: decodes a round-robin time-multiplexed
// (pos_spike, neg_spike) stream into per-channel signed reconstructions.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of delta_demodulator_multichannel_if
//              (beat in: en/pos_spike/neg_spike/sync, clr, cfg_* delta writes;
//               out: sample_out/channel_out/valid_out, sticky err)
// Two stages: stage 1 latches the beat and its channel's delta, stage 2
// updates the accumulator with saturation and registers the output.

// Per-channel state: programmable delta and reconstruction accumulator.
module delta_demodulator_multichannel_lane #(
  parameter int                      WIDTH         = 16,
  parameter logic signed [WIDTH-1:0] DEFAULT_DELTA = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    dlt_we,
  input  logic signed [WIDTH-1:0] dlt_d,
  input  logic                    acc_we,
  input  logic signed [WIDTH-1:0] acc_d,
  output logic signed [WIDTH-1:0] dlt_q,
  output logic signed [WIDTH-1:0] acc_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      dlt_q <= DEFAULT_DELTA;
      acc_q <= '0;
    end else begin
      if (dlt_we) dlt_q <= dlt_d;
      if (clr)         acc_q <= '0;
      else if (acc_we) acc_q <= acc_d;
    end
  end
endmodule

module delta_demodulator_multichannel #(
  parameter int                      CHANNELS      = 16,
  parameter int                      WIDTH         = 16,
  parameter logic signed [WIDTH-1:0] DEFAULT_DELTA = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  delta_demodulator_multichannel_if.slave  bus
);
  localparam int            CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] dlt_q;
  logic [CHANNELS-1:0][WIDTH-1:0] acc_q;

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           beat_ch;
  logic [1:0]              vld_pipe;   // [0] stage 1 holds a beat, [1] output valid
  logic [CW-1:0]           s1_ch;
  logic                    s1_pos;
  logic                    s1_neg;
  logic signed [WIDTH-1:0] s1_dlt;
  logic signed [WIDTH-1:0] acc_rd;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] nxt;
  logic signed [WIDTH-1:0] sample_r;
  logic [CW-1:0]           channel_r;
  logic                    err_r;

  assign beat_ch = bus.sync ? '0 : cnt;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    delta_demodulator_multichannel_lane #(
      .WIDTH         (WIDTH),
      .DEFAULT_DELTA (DEFAULT_DELTA)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (bus.clr),
      // out-of-range cfg_addr matches no lane, so it is dropped here
      .dlt_we (bus.cfg_we && (bus.cfg_addr == CW'(g))),
      .dlt_d  (bus.cfg_delta),
      .acc_we (vld_pipe[0] && (s1_ch == CW'(g))),
      .acc_d  (nxt),
      .dlt_q  (dlt_q[g]),
      .acc_q  (acc_q[g])
    );
  end

  // The accumulator is written on the stage-2 edge, so a same-channel beat
  // in stage 1 on the following cycle already reads the updated value:
  // back-to-back beats chain without an explicit bypass path.
  assign acc_rd = acc_q[s1_ch];

  always_comb begin
    sum = {acc_rd[WIDTH-1], acc_rd};
    if (s1_pos && !s1_neg)
      sum = {acc_rd[WIDTH-1], acc_rd} + {s1_dlt[WIDTH-1], s1_dlt};
    else if (!s1_pos && s1_neg)
      sum = {acc_rd[WIDTH-1], acc_rd} - {s1_dlt[WIDTH-1], s1_dlt};
    // the WIDTH+1-bit sum cannot wrap; top two bits differing means overflow
    nxt = sum[WIDTH-1:0];
    if (sum[WIDTH] != sum[WIDTH-1])
      nxt = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      vld_pipe  <= '0;
      s1_ch     <= '0;
      s1_pos    <= 1'b0;
      s1_neg    <= 1'b0;
      s1_dlt    <= '0;
      sample_r  <= '0;
      channel_r <= '0;
      err_r     <= 1'b0;
    end else if (bus.clr) begin
      // beat on this edge and the one in stage 1 are both dropped
      cnt      <= '0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.en};
      if (bus.en) begin
        cnt    <= (beat_ch == LAST) ? '0 : beat_ch + CW'(1);
        s1_ch  <= beat_ch;
        s1_pos <= bus.pos_spike;
        s1_neg <= bus.neg_spike;
        s1_dlt <= dlt_q[beat_ch];   // pre-write value if cfg hits same lane
      end
      if (vld_pipe[0]) begin
        sample_r  <= nxt;
        channel_r <= s1_ch;
        if (s1_pos && s1_neg) err_r <= 1'b1;
      end
    end
  end

  assign bus.sample_out  = sample_r;
  assign bus.channel_out = channel_r;
  assign bus.valid_out   = vld_pipe[1];
  assign bus.err         = err_r;
endmodule

// File: tb/tb_delta_demodulator_multichannel.sv
module tb_delta_demodulator_multichannel;
  logic clk = 1'b0;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  always #5 clk = ~clk;

  delta_demodulator_multichannel_if #(.CHANNELS(4), .WIDTH(8)) ia ();
  delta_demodulator_multichannel_if #(.CHANNELS(3), .WIDTH(8)) ib ();
  delta_demodulator_multichannel_if #(.CHANNELS(1), .WIDTH(8)) ic ();

  delta_demodulator_multichannel #(.CHANNELS(4), .WIDTH(8), .DEFAULT_DELTA(8'sd4))
    dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  delta_demodulator_multichannel #(.CHANNELS(3), .WIDTH(8), .DEFAULT_DELTA(8'sd4))
    dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));
  delta_demodulator_multichannel #(.CHANNELS(1), .WIDTH(8), .DEFAULT_DELTA(8'sd4))
    dut_c (.clk(clk), .rst(rst_c), .bus(ic.slave));

  int n_chk = 0, n_fail = 0;

  // Reference model for the 4-channel DUT: one beat at a time, plain ints.
  int m_acc[4], m_delta[4], m_cnt;
  bit m_err;
  bit p_vld, p_bad;  int p_smp, p_ch;   // beat taken on last edge
  bit e_vld;         int e_smp, e_ch;   // what the outputs must show now

  function automatic void a_model(bit r, bit en, bit pos, bit neg, bit sync,
                                  bit clr, bit we, int addr, int dlt);
    int ch, nx;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_delta[i] = 4; end
      m_cnt = 0; m_err = 0; p_vld = 0; e_vld = 0;
    end else begin
      if (clr) begin
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_cnt = 0; p_vld = 0; e_vld = 0;
      end else begin
        e_vld = p_vld; e_smp = p_smp; e_ch = p_ch;
        if (p_vld && p_bad) m_err = 1;
        p_vld = en;
        if (en) begin
          ch = sync ? 0 : m_cnt;
          m_cnt = (ch + 1) % 4;
          nx = m_acc[ch];
          if (pos && !neg) nx = nx + m_delta[ch];
          else if (neg && !pos) nx = nx - m_delta[ch];
          if (nx > 127) nx = 127;
          if (nx < -128) nx = -128;
          m_acc[ch] = nx; p_smp = nx; p_ch = ch; p_bad = pos && neg;
        end
      end
      if (we && addr < 4) m_delta[addr] = dlt;
    end
  endfunction

  task automatic a_cycle(bit r, bit en, bit pos, bit neg, bit sync, bit clr,
                         bit we, int addr, int dlt);
    @(negedge clk);
    rst_a = r; ia.en = en; ia.pos_spike = pos; ia.neg_spike = neg; ia.sync = sync;
    ia.clr = clr; ia.cfg_we = we; ia.cfg_addr = 2'(addr); ia.cfg_delta = 8'(dlt);
    @(posedge clk);
    a_model(r, en, pos, neg, sync, clr, we, addr, dlt);
    #1;
  endtask

  task automatic b_cycle(bit r, bit en, bit pos, bit sync, bit we, int addr, int dlt);
    @(negedge clk);
    rst_b = r; ib.en = en; ib.pos_spike = pos; ib.neg_spike = 1'b0; ib.sync = sync;
    ib.clr = 1'b0; ib.cfg_we = we; ib.cfg_addr = 2'(addr); ib.cfg_delta = 8'(dlt);
    @(posedge clk); #1;
  endtask

  task automatic c_cycle(bit r, bit en, bit pos);
    @(negedge clk);
    rst_c = r; ic.en = en; ic.pos_spike = pos; ic.neg_spike = 1'b0; ic.sync = 1'b0;
    ic.clr = 1'b0; ic.cfg_we = 1'b0; ic.cfg_addr = 1'b0; ic.cfg_delta = 8'sd0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    a_cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);
    a_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (ia.valid_out !== 1'b0 || ia.err !== 1'b0 || ia.sample_out !== 8'd0 ||
        ia.channel_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b err=%b sample=%0d ch=%0d, expected all 0",
               ia.valid_out, ia.err, ia.sample_out, ia.channel_out);
    end
  endtask

  task automatic test_round_robin();
    int q0[$], chs[$];
    for (int i = 0; i < 14; i++) begin
      a_cycle(0, i < 12, (i % 4) == 0, 0, 0, 0, 0, 0, 0);
      n_chk++;
      if (ia.valid_out !== e_vld || ia.err !== m_err ||
          (e_vld && ($signed(ia.sample_out) != e_smp || ia.channel_out != e_ch))) begin
        n_fail++;
        $display("FAIL rr_cyc%0d: valid=%b sample=%0d ch=%0d err=%b, expected %b %0d %0d %b",
                 i, ia.valid_out, $signed(ia.sample_out), ia.channel_out, ia.err,
                 e_vld, e_smp, e_ch, m_err);
      end
      if (ia.valid_out === 1'b1) begin
        chs.push_back(int'(ia.channel_out));
        if (ia.channel_out == 0) q0.push_back(int'($signed(ia.sample_out)));
      end
    end
    n_chk++;
    if (chs.size() != 12 || q0.size() != 3 || q0[0] != 4 || q0[1] != 8 || q0[2] != 12) begin
      n_fail++;
      $display("FAIL rr_ch0: %0d outputs, ch0=%p, expected 12 outputs, ch0 4 8 12",
               chs.size(), q0);
    end
    for (int i = 0; i < chs.size(); i++) begin
      n_chk++;
      if (chs[i] != i % 4) begin
        n_fail++;
        $display("FAIL rr_order%0d: ch=%0d, expected %0d", i, chs[i], i % 4);
      end
    end
  endtask

  task automatic test_saturation();
    int q1[$];
    int exp1[6] = '{100, 127, 27, -73, -128, -128};
    a_cycle(0, 0, 0, 0, 0, 0, 1, 1, 100);
    for (int i = 0; i < 26; i++) begin
      a_cycle(0, i < 24, (i % 4 == 1) && (i / 4 < 2), (i % 4 == 1) && (i / 4 >= 2),
              i == 0, 0, 0, 0, 0);
      n_chk++;
      if (ia.valid_out !== e_vld ||
          (e_vld && ($signed(ia.sample_out) != e_smp || ia.channel_out != e_ch))) begin
        n_fail++;
        $display("FAIL sat_cyc%0d: valid=%b sample=%0d ch=%0d, expected %b %0d %0d",
                 i, ia.valid_out, $signed(ia.sample_out), ia.channel_out, e_vld, e_smp, e_ch);
      end
      if (ia.valid_out === 1'b1 && ia.channel_out == 1)
        q1.push_back(int'($signed(ia.sample_out)));
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (q1.size() != 6 || q1[i] != exp1[i]) begin
        n_fail++;
        $display("FAIL sat_ch1_%0d: got %p, expected %0d", i, q1, exp1[i]);
      end
    end
  endtask

  task automatic test_illegal_pair();
    int last2 = -999;
    for (int i = 0; i < 14; i++) begin
      a_cycle(0, i < 12, (i % 4 == 2), (i % 4 == 2) && (i / 4 == 2), i == 0, 0, 0, 0, 0);
      n_chk++;
      if (ia.valid_out !== e_vld || ia.err !== m_err ||
          (e_vld && ($signed(ia.sample_out) != e_smp || ia.channel_out != e_ch))) begin
        n_fail++;
        $display("FAIL ill_cyc%0d: valid=%b sample=%0d ch=%0d err=%b, expected %b %0d %0d %b",
                 i, ia.valid_out, $signed(ia.sample_out), ia.channel_out, ia.err,
                 e_vld, e_smp, e_ch, m_err);
      end
      if (ia.valid_out === 1'b1 && ia.channel_out == 2) last2 = int'($signed(ia.sample_out));
    end
    n_chk++;
    if (last2 != 8 || ia.err !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_pair: sample=%0d err=%b, expected 8 and 1", last2, ia.err);
    end
    for (int i = 0; i < 50; i++) a_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (ia.err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, expected 1", ia.err);
    end
    // clr on top of a beat: beat dropped, err kept
    a_cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
    a_cycle(0, 1, 1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (ia.valid_out !== 1'b0 || ia.err !== 1'b1) begin
        n_fail++;
        $display("FAIL clr_cyc%0d: valid=%b err=%b, expected 0 1", i, ia.valid_out, ia.err);
      end
      a_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    a_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (ia.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_rst: err=%b, expected 0", ia.err);
    end
  endtask

  task automatic test_cfg_collision();
    int q0[$];
    for (int i = 0; i < 7; i++) begin
      a_cycle(0, i < 5, (i == 0) || (i == 4), 0, 0, 0, i == 0, 0, 9);
      n_chk++;
      if (ia.valid_out !== e_vld ||
          (e_vld && ($signed(ia.sample_out) != e_smp || ia.channel_out != e_ch))) begin
        n_fail++;
        $display("FAIL col_cyc%0d: valid=%b sample=%0d ch=%0d, expected %b %0d %0d",
                 i, ia.valid_out, $signed(ia.sample_out), ia.channel_out, e_vld, e_smp, e_ch);
      end
      if (ia.valid_out === 1'b1 && ia.channel_out == 0)
        q0.push_back(int'($signed(ia.sample_out)));
    end
    n_chk++;
    if (q0.size() != 2 || q0[0] != 4 || q0[1] != 13) begin
      n_fail++;
      $display("FAIL cfg_collision: ch0=%p, expected 4 13", q0);
    end
  endtask

  task automatic test_random();
    bit en, pos, neg, sync, clr, we;
    int addr, dlt;
    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      pos  = $urandom_range(0, 1);
      neg  = pos ? ($urandom_range(0, 7) == 0) : bit'($urandom_range(0, 1));
      sync = ($urandom_range(0, 7) == 0);
      clr  = ($urandom_range(0, 49) == 0);
      we   = ($urandom_range(0, 9) == 0);
      addr = $urandom_range(0, 3);
      dlt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                         : int'($urandom_range(0, 80)) - 40;
      a_cycle(0, en, pos, neg, sync, clr, we, addr, dlt);
      n_chk++;
      if (ia.valid_out !== e_vld || ia.err !== m_err ||
          (e_vld && ($signed(ia.sample_out) != e_smp || ia.channel_out != e_ch))) begin
        n_fail++;
        $display("FAIL rnd_cyc%0d: valid=%b sample=%0d ch=%0d err=%b, expected %b %0d %0d %b",
                 i, ia.valid_out, $signed(ia.sample_out), ia.channel_out, ia.err,
                 e_vld, e_smp, e_ch, m_err);
      end
    end
  endtask

  task automatic test_sync_realign();
    int chs[$], smp[$];
    int exp_ch[7] = '{0, 1, 0, 1, 2, 0, 1};
    b_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      b_cycle(0, i < 7, 0, i == 2, 0, 0, 0);
      if (ib.valid_out === 1'b1) chs.push_back(int'(ib.channel_out));
    end
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (chs.size() != 7 || chs[i] != exp_ch[i]) begin
        n_fail++;
        $display("FAIL sync_seq%0d: got %p, expected %0d", i, chs, exp_ch[i]);
      end
    end
    // index 3 does not exist with 3 channels: write must not land anywhere
    b_cycle(0, 0, 0, 0, 1, 3, 50);
    for (int i = 0; i < 5; i++) begin
      b_cycle(0, i < 3, 1, i == 0, 0, 0, 0);
      if (ib.valid_out === 1'b1) smp.push_back(int'($signed(ib.sample_out)));
    end
    n_chk++;
    if (smp.size() != 3 || smp[0] != 4 || smp[1] != 4 || smp[2] != 4) begin
      n_fail++;
      $display("FAIL cfg_oob: got %p, expected 4 4 4", smp);
    end
  endtask

  task automatic test_back_to_back();
    int smp[$];
    c_cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      c_cycle(0, i < 3, 1);
      n_chk++;
      if (ic.valid_out !== (i >= 1 && i <= 3)) begin
        n_fail++;
        $display("FAIL b2b_valid%0d: valid=%b, expected %b", i, ic.valid_out, i >= 1 && i <= 3);
      end
      if (ic.valid_out === 1'b1) smp.push_back(int'($signed(ic.sample_out)));
    end
    n_chk++;
    if (smp.size() != 3 || smp[0] != 4 || smp[1] != 8 || smp[2] != 12) begin
      n_fail++;
      $display("FAIL b2b_chain: got %p, expected 4 8 12", smp);
    end
    c_cycle(0, 1, 1);   // in flight when reset hits
    c_cycle(1, 1, 1);
    n_chk++;
    if (ic.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush0: valid=%b, expected 0", ic.valid_out);
    end
    c_cycle(0, 0, 0);
    n_chk++;
    if (ic.valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush1: valid=%b, expected 0", ic.valid_out);
    end
    c_cycle(0, 1, 1);
    c_cycle(0, 0, 0);
    n_chk++;
    if (ic.valid_out !== 1'b1 || $signed(ic.sample_out) != 8'sd4) begin
      n_fail++;
      $display("FAIL rst_restart: valid=%b sample=%0d, expected 1 4",
               ic.valid_out, $signed(ic.sample_out));
    end
  endtask

  initial begin
    {ia.en, ia.pos_spike, ia.neg_spike, ia.sync, ia.clr, ia.cfg_we} = '0;
    {ib.en, ib.pos_spike, ib.neg_spike, ib.sync, ib.clr, ib.cfg_we} = '0;
    {ic.en, ic.pos_spike, ic.neg_spike, ic.sync, ic.clr, ic.cfg_we} = '0;
    ia.cfg_addr = '0; ia.cfg_delta = '0;
    ib.cfg_addr = '0; ib.cfg_delta = '0;
    ic.cfg_addr = '0; ic.cfg_delta = '0;
    test_reset();
    test_round_robin();
    test_saturation();
    test_illegal_pair();
    test_cfg_collision();
    test_random();
    test_sync_realign();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delta_demodulator_multichannel.md
Name: delta_demodulator_multichannel

Overview:
Per-channel delta demodulator: the decoder for the multichannel delta modulator's time-multiplexed spike stream. It consumes one (pos_spike, neg_spike) pair per enabled beat, with channels in round-robin order, and keeps a per-channel reconstruction accumulator. On each beat it steps that channel's accumulator up or down by the channel's programmable delta and emits the reconstructed signed sample tagged with its channel index. It sits after the spike link / SNN output and feeds reconstruction monitors and DAC paths.

Parameters:
CHANNELS, 16, number of time-multiplexed channels; any value >= 1, need not be a power of two.
WIDTH, 16, signed sample and delta width.
DEFAULT_DELTA, 1, reset value loaded into every per-channel delta register (signed WIDTH).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
en  input  1  beat valid; pos_spike/neg_spike/sync are sampled only when en=1
pos_spike  input  1  step current channel up by its delta
neg_spike  input  1  step current channel down by its delta
sync  input  1  with en=1: this beat belongs to channel 0 (frame realignment)
clr  input  1  zero all accumulators and the channel counter; deltas kept
cfg_we  input  1  delta register write strobe
cfg_addr  input  clog2(CHANNELS) (min 1)  delta register index
cfg_delta  input  WIDTH  signed delta value to write
sample_out  output  WIDTH  reconstructed signed sample
channel_out  output  clog2(CHANNELS) (min 1)  channel of sample_out
valid_out  output  1  sample_out/channel_out valid this cycle
err  output  1  sticky: a beat arrived with pos_spike=neg_spike=1

Behaviour:
- Reset (rst=1), applied at the clock edge, has priority over everything else:
  - accumulators, channel counter, pipeline regs, sample_out, channel_out, valid_out and err all go to 0;
  - every delta register is loaded with DEFAULT_DELTA.
- Channel counter:
  - beat channel = 0 if sync=1, otherwise the counter value;
  - after an en beat the counter becomes beat channel + 1, wrapping from CHANNELS-1 to 0;
  - the counter holds when en=0.
- Stage 1 (the en edge) registers en, beat channel, the spike pair, and the delta of that channel. A cfg write to the same index on the same edge has no effect on this beat; the old delta is used.
- Stage 2 (the next edge):
  - reads the accumulator of the stage-1 channel;
  - computes next = acc+delta (pos only), acc-delta (neg only), or acc (neither, or both);
  - writes next back to the accumulator;
  - registers sample_out=next, channel_out=channel, valid_out=1.
- Latency: en high at edge t gives valid_out high after edge t+1, i.e. 2 cycles. Throughput is 1 beat per cycle.
- Hazard: back-to-back beats to the same channel (CHANNELS=1, or repeated sync) must chain correctly. The stage-2 result forwards to a same-channel read on the following edge, so two consecutive +delta beats give +2*delta.
- Arithmetic:
  - computed in WIDTH+1 bits, then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1];
  - delta is signed, so a negative delta inverts the step direction, and the result is still saturated.
- Illegal pair: pos_spike=neg_spike=1 on an en beat leaves the accumulator unchanged but still emits a valid output. err sets at stage 2 and stays set until rst.
- cfg writes: cfg_we writes cfg_delta to delta[cfg_addr] at the edge. cfg_addr >= CHANNELS is ignored. Writes are allowed at any time, independent of en.
- clr (no rst):
  - zeros all accumulators and the channel counter and flushes both pipeline stages, so valid_out=0 next cycle;
  - deltas and err are unchanged;
  - clr takes priority over en on the same edge, so that beat is dropped.
- Reset mid-stream: in-flight beats are discarded and no valid_out is produced for them.
- valid_out is a one-cycle pulse per beat; there is no backpressure.

Test Plan:
1. CHANNELS=4, WIDTH=8, DEFAULT_DELTA=4; rst, then 12 consecutive en beats with pos_spike=1 only on channel-0 beats -> channel 0 outputs 4, 8, 12; channels 1-3 output 0. Each valid_out appears 2 cycles after its en, and channel_out cycles 0,1,2,3.
2. cfg write delta[1]=100; two pos beats on ch1 -> 100 then 127 (saturated). Then four neg beats on ch1 -> 27, -73, -128, -128.
3. CHANNELS=3; 7 en beats, the third with sync=1 -> channel_out sequence 0,1,0,1,2,0,1.
4. Beat with pos=neg=1 on ch2 holding 8 -> sample_out=8, valid_out=1, err=1 and still set 50 cycles later. clr leaves err=1; rst clears it.
5. cfg_we to ch0 with delta 9 on the same edge as a ch0 pos beat (acc 0, delta 4) -> output 4; the next ch0 pos beat -> 13.
6. CHANNELS=1; 3 consecutive pos beats with delta 4 -> outputs 4, 8, 12 (forwarding). Then rst asserted with en high -> valid_out=0 the next two cycles, and a later beat outputs 4.
